// File: rtl/cop0_irq_timer_pkg.sv
// Shared coprocessor-0 constants for the interrupt/timer block: register
// addresses, Cause bit positions and the pending-interrupt priority encoder.
package cop0_info;

    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [2:0] SEL_COUNT   = 3'd0;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [2:0] SEL_COMPARE = 3'd0;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [2:0] SEL_STATUS  = 3'd0;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [2:0] SEL_CAUSE   = 3'd0;

    localparam int unsigned IDX_CAUSE_TI       = 30;
    localparam int unsigned IDX_CAUSE_IP_TIMER = 7;
    localparam int unsigned IDX_CAUSE_IP_SW_E  = 9;
    localparam int unsigned IDX_CAUSE_IP_SW_S  = 8;
    localparam int unsigned IDX_CAUSE_IP_HW_S  = 10;

    // Index of the highest set bit; bit 7 has the highest priority, 0 if none set.
    function automatic logic [2:0] highest_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cop0_irq_timer_sync.sv
// Multi-stage synchroniser for a bundle of asynchronous level inputs.
module cop0_irq_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    // Shift the raw inputs through the flop chain; stage 0 samples the pins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cop0_irq_timer.sv
// Coprocessor-0 Count/Compare timer, Cause.IP/TI ownership and the registered,
// prioritised interrupt request handed to the exception unit.
module cop0_irq_timer
    import cop0_info::*;
#(
    parameter int unsigned HW_IRQ_NUM  = 6,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [HW_IRQ_NUM-1:0] hw_irq_i,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [2:0]            wsel_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            rsel_i,
    output logic [31:0]           rdata_o,
    output logic                  rhit_o,
    input  logic                  status_ie_i,
    input  logic                  status_exl_i,
    input  logic                  status_erl_i,
    input  logic [7:0]            status_im_i,
    input  logic                  cause_dc_i,
    output logic [7:0]            ip_o,
    output logic                  ti_o,
    output logic                  irq_req_o,
    output logic [2:0]            irq_idx_o
);

    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [3:0]            presc_q, presc_d;
    logic                  ti_q, ti_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic                  irq_req_q, irq_req_d;
    logic [2:0]            irq_idx_q, irq_idx_d;

    logic [HW_IRQ_NUM-1:0] hw_sync_s;
    logic [5:0]            hw_pad_s;
    logic [7:0]            ip_s;
    logic [7:0]            pend_s;
    logic [31:0]           count_inc_s;
    logic                  tick_s;
    logic                  wr_count_s;
    logic                  wr_compare_s;
    logic                  wr_cause_s;

    cop0_irq_sync #(
        .WIDTH  (HW_IRQ_NUM),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (hw_irq_i),
        .sync_o  (hw_sync_s)
    );

    assign wr_count_s   = we_i && (waddr_i == RD_COUNT)   && (wsel_i == SEL_COUNT);
    assign wr_compare_s = we_i && (waddr_i == RD_COMPARE) && (wsel_i == SEL_COMPARE);
    assign wr_cause_s   = we_i && (waddr_i == RD_CAUSE)   && (wsel_i == SEL_CAUSE);

    assign tick_s      = !cause_dc_i && (presc_q == DIV_LAST);
    assign count_inc_s = count_q + 32'd1;

    // Line 5 shares IP[7] with the timer; narrower configurations pad with zeros.
    assign hw_pad_s = 6'(hw_sync_s);
    assign ip_s     = {ti_q | hw_pad_s[5], hw_pad_s[4:0], ip_sw_q};
    assign pend_s   = ip_s & status_im_i;

    // Next-state logic for the prescaler, Count, Compare, TI and software IP bits.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        ip_sw_d   = ip_sw_q;

        if (wr_count_s) begin
            presc_d = 4'd0;
            count_d = wdata_i;
        end else if (cause_dc_i) begin
            presc_d = presc_q;
        end else if (tick_s) begin
            presc_d = 4'd0;
            count_d = count_inc_s;
        end else begin
            presc_d = presc_q + 4'd1;
        end

        // Only a real increment can raise TI; a Compare write always clears it.
        if (wr_compare_s) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (tick_s && !wr_count_s && (count_inc_s == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end

        if (wr_cause_s) begin
            ip_sw_d = wdata_i[IDX_CAUSE_IP_SW_E:IDX_CAUSE_IP_SW_S];
        end else begin
            ip_sw_d = ip_sw_q;
        end
    end

    // Request and index are computed from the current IP and Status each cycle.
    always_comb begin
        irq_req_d = status_ie_i && !status_exl_i && !status_erl_i && (|pend_s);
        irq_idx_d = highest_idx(pend_s);
    end

    // State registers, all returning to their reset values asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            presc_q   <= 4'd0;
            ti_q      <= 1'b0;
            ip_sw_q   <= 2'b00;
            irq_req_q <= 1'b0;
            irq_idx_q <= 3'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
            ti_q      <= ti_d;
            ip_sw_q   <= ip_sw_d;
            irq_req_q <= irq_req_d;
            irq_idx_q <= irq_idx_d;
        end
    end

    // Read mux for the three owned addresses; everything else misses.
    always_comb begin
        rdata_o = 32'h0000_0000;
        rhit_o  = 1'b0;
        case ({raddr_i, rsel_i})
            {RD_COUNT, SEL_COUNT}: begin
                rdata_o = count_q;
                rhit_o  = 1'b1;
            end
            {RD_COMPARE, SEL_COMPARE}: begin
                rdata_o = compare_q;
                rhit_o  = 1'b1;
            end
            {RD_CAUSE, SEL_CAUSE}: begin
                rdata_o[IDX_CAUSE_TI]              = ti_q;
                rdata_o[IDX_CAUSE_IP_SW_S +: 8]    = ip_s;
                rhit_o                             = 1'b1;
            end
            default: begin
                rdata_o = 32'h0000_0000;
                rhit_o  = 1'b0;
            end
        endcase
    end

    assign ip_o      = ip_s;
    assign ti_o      = ti_q;
    assign irq_req_o = irq_req_q;
    assign irq_idx_o = irq_idx_q;

endmodule

// File: tb/tb_cop0_irq_timer.sv
// Directed bench for cop0_irq_timer: a register access table plus hand-written
// timer, synchroniser, masking and asynchronous reset sequences.
module tb_cop0_irq_timer;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_irq;
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [31:0] rdata;
    logic        rhit;
    logic        status_ie, status_exl, status_erl;
    logic [7:0]  status_im;
    logic        cause_dc;
    logic [7:0]  ip;
    logic        ti;
    logic        irq_req;
    logic [2:0]  irq_idx;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [2:0]  ws;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [2:0]  rs;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t tbl[8];

    cop0_irq_timer #(
        .HW_IRQ_NUM  (6),
        .COUNT_DIV   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .hw_irq_i     (hw_irq),
        .we_i         (we),
        .waddr_i      (waddr),
        .wsel_i       (wsel),
        .wdata_i      (wdata),
        .raddr_i      (raddr),
        .rsel_i       (rsel),
        .rdata_o      (rdata),
        .rhit_o       (rhit),
        .status_ie_i  (status_ie),
        .status_exl_i (status_exl),
        .status_erl_i (status_erl),
        .status_im_i  (status_im),
        .cause_dc_i   (cause_dc),
        .ip_o         (ip),
        .ti_o         (ti),
        .irq_req_o    (irq_req),
        .irq_idx_o    (irq_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        raddr = a;
        rsel  = 3'd0;
        #1;
        chk(name, rdata, exp);
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wsel  = 3'd0;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b1, A_COMPARE, 3'd0, 32'h1234_5678, A_COMPARE, 3'd0, 32'h1234_5678, 1'b1};
        tbl[1] = '{1'b1, A_COUNT,   3'd0, 32'hA5A5_0000, A_COUNT,   3'd0, 32'hA5A5_0000, 1'b1};
        tbl[2] = '{1'b1, A_CAUSE,   3'd0, 32'hFFFF_FFFF, A_CAUSE,   3'd0, 32'h0000_0300, 1'b1};
        tbl[3] = '{1'b1, A_CAUSE,   3'd0, 32'h0000_0100, A_CAUSE,   3'd0, 32'h0000_0100, 1'b1};
        tbl[4] = '{1'b0, A_CAUSE,   3'd0, 32'h0000_0000, A_STATUS,  3'd0, 32'h0000_0000, 1'b0};
        tbl[5] = '{1'b0, A_COUNT,   3'd0, 32'h0000_0000, A_COUNT,   3'd1, 32'h0000_0000, 1'b0};
        tbl[6] = '{1'b1, A_CAUSE,   3'd0, 32'h0000_0000, A_CAUSE,   3'd0, 32'h0000_0000, 1'b1};
        tbl[7] = '{1'b1, A_STATUS,  3'd0, 32'hDEAD_BEEF, A_COMPARE, 3'd0, 32'h1234_5678, 1'b1};

        reset = 1'b1;  hw_irq = 6'd0;  we = 1'b0;  waddr = 5'd0;  wsel = 3'd0;
        wdata = 32'd0; raddr = 5'd0;   rsel = 3'd0;
        status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0;
        status_im = 8'h00; cause_dc = 1'b0;

        // Reset state
        step(3);
        chk("rst_ip", 32'(ip), 32'h0);
        chk("rst_ti", 32'(ti), 32'h0);
        chk("rst_irq_req", 32'(irq_req), 32'h0);
        chk("rst_irq_idx", 32'(irq_idx), 32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);
        rd_chk("rst_compare", A_COMPARE, 32'hFFFF_FFFF);

        // Prescaler: two clocks per increment from reset release
        reset = 1'b0;
        step(10);
        rd_chk("presc_count5", A_COUNT, 32'd5);
        wr(A_COMPARE, 32'h0000_1000);
        wr(A_COUNT, 32'hFFFF_FFFE);
        step(2);
        rd_chk("presc_count_ff", A_COUNT, 32'hFFFF_FFFF);
        step(2);
        rd_chk("presc_wrap", A_COUNT, 32'h0);
        chk("presc_wrap_ti", 32'(ti), 32'h0);

        // Register access table with Count frozen
        cause_dc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we    = tbl[i].we;
            waddr = tbl[i].wa;
            wsel  = tbl[i].ws;
            wdata = tbl[i].wd;
            raddr = tbl[i].ra;
            rsel  = tbl[i].rs;
            @(posedge clk);
            @(negedge clk);
            we = 1'b0;
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_rhit", i), 32'(rhit), 32'(tbl[i].exp_hit));
        end
        step(4);
        rd_chk("dc_hold", A_COUNT, 32'hA5A5_0000);
        cause_dc = 1'b0;

        // Timer interrupt
        status_im = 8'h80; status_ie = 1'b1;
        wr(A_COMPARE, 32'h0000_0010);
        wr(A_COUNT, 32'h0000_000E);
        step(3);
        chk("tmr_ti_early", 32'(ti), 32'h0);
        step(1);
        chk("tmr_ti_set", 32'(ti), 32'h1);
        chk("tmr_ip", 32'(ip), 32'h80);
        chk("tmr_req_lag", 32'(irq_req), 32'h0);
        rd_chk("tmr_cause", A_CAUSE, 32'h4000_8000);
        step(1);
        chk("tmr_req", 32'(irq_req), 32'h1);
        chk("tmr_idx", 32'(irq_idx), 32'h7);
        wr(A_COMPARE, 32'h0000_2000);
        chk("tmr_ti_clr", 32'(ti), 32'h0);
        step(1);
        chk("tmr_req_clr", 32'(irq_req), 32'h0);

        // Compare write on the edge Count reaches the old Compare
        wr(A_COMPARE, 32'h0000_0101);
        wr(A_COUNT, 32'h0000_0100);
        step(1);
        wr(A_COMPARE, 32'h0000_5000);
        chk("sim_cmp_ti", 32'(ti), 32'h0);
        rd_chk("sim_cmp_count", A_COUNT, 32'h0000_0101);

        // Count write clears the prescaler, and beats a same-edge increment
        wr(A_COUNT, 32'h0000_0200);
        wr(A_COUNT, 32'h0000_0300);
        step(1);
        rd_chk("presc_clear", A_COUNT, 32'h0000_0300);
        wr(A_COUNT, 32'h0000_3000);
        rd_chk("sim_cnt_wins", A_COUNT, 32'h0000_3000);

        // Count written equal to Compare must not raise TI
        wr(A_COUNT, 32'h0000_5000);
        chk("cnt_eq_ti0", 32'(ti), 32'h0);
        step(1);
        chk("cnt_eq_ti1", 32'(ti), 32'h0);

        // Hardware lines through the synchroniser and priority encoder
        status_im = 8'hFF;
        hw_irq = 6'b001001;
        step(1);
        chk("hw_ip_stage1", 32'(ip), 32'h00);
        step(1);
        chk("hw_ip", 32'(ip), 32'h24);
        chk("hw_req_lag", 32'(irq_req), 32'h0);
        step(1);
        chk("hw_req", 32'(irq_req), 32'h1);
        chk("hw_idx", 32'(irq_idx), 32'h5);
        hw_irq = 6'b100000;
        step(2);
        chk("hw5_ip", 32'(ip), 32'h80);
        step(1);
        chk("hw5_idx", 32'(irq_idx), 32'h7);
        hw_irq = 6'b000000;
        step(3);
        chk("hw_ip_off", 32'(ip), 32'h00);
        chk("hw_req_off", 32'(irq_req), 32'h0);

        // Masking by EXL, then release
        status_exl = 1'b1;
        wr(A_CAUSE, 32'h0000_0300);
        chk("mask_ip", 32'(ip), 32'h03);
        step(1);
        chk("mask_req_exl", 32'(irq_req), 32'h0);
        status_exl = 1'b0;
        step(1);
        chk("mask_req", 32'(irq_req), 32'h1);
        chk("mask_idx", 32'(irq_idx), 32'h1);
        status_erl = 1'b1;
        step(1);
        chk("mask_req_erl", 32'(irq_req), 32'h0);
        status_erl = 1'b0;

        // Asynchronous reset mid-count with TI pending
        status_im = 8'h80;
        wr(A_COMPARE, 32'h0000_7001);
        wr(A_COUNT, 32'h0000_7000);
        step(2);
        chk("ar_ti_pre", 32'(ti), 32'h1);
        step(1);
        chk("ar_req_pre", 32'(irq_req), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ti", 32'(ti), 32'h0);
        chk("ar_ip", 32'(ip), 32'h0);
        chk("ar_req", 32'(irq_req), 32'h0);
        chk("ar_idx", 32'(irq_idx), 32'h0);
        rd_chk("ar_count", A_COUNT, 32'h0);
        rd_chk("ar_compare", A_COMPARE, 32'hFFFF_FFFF);
        step(1);
        reset = 1'b0;
        step(2);
        rd_chk("ar_first_inc", A_COUNT, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cop0_irq_timer.md
# cop0_irq_timer

Parametrised interrupt and timer block for coprocessor 0. It owns Count, Compare, Cause.TI and Cause.IP, synchronises external interrupt lines, and adds a configurable Count prescaler and a registered, prioritised interrupt request. It sits beside the cop0 register file. Status bits come in from that file; `irq_req` and `irq_idx` go out to the exception unit.

## Interface
Parameters:
- `HW_IRQ_NUM`, default 6: external interrupt lines, 1..6. Line k maps to IP[k+2].
- `COUNT_DIV`, default 2: clocks per Count increment, 1..16.
- `SYNC_STAGES`, default 2: synchroniser flops per line, 2..4.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `hw_irq` in HW_IRQ_NUM: raw asynchronous level interrupts.
- `we` in 1: mtc0 write strobe.
- `waddr` in 5: mtc0 rd field.
- `wsel` in 3: mtc0 sel field.
- `wdata` in 32: mtc0 data.
- `raddr` in 5: mfc0 rd field.
- `rsel` in 3: mfc0 sel field.
- `rdata` out 32: combinational read data.
- `rhit` out 1: raddr/rsel is owned by this block.
- `status_ie`, `status_exl`, `status_erl` in 1 each: current Status bits.
- `status_im` in 8: Status.IM.
- `cause_dc` in 1: disable Count.
- `ip` out 8: current Cause.IP.
- `ti` out 1: Cause.TI.
- `irq_req` out 1: registered interrupt request.
- `irq_idx` out 3: highest pending enabled IP index.

## Operation
- Owned registers:
  - Count: RD_COUNT/SEL_COUNT.
  - Compare: RD_COMPARE/SEL_COMPARE.
  - Cause bits IP[1:0] (RW), IP[7:2] (R) and TI (R). A Cause read returns only these bits; all other bits read 0. `rhit` is 1 for these three addresses only.
- Synchroniser: each `hw_irq` bit passes through SYNC_STAGES flops. Line k drives IP[k+2]. IP bits above HW_IRQ_NUM+1 are 0, except IP[7] as below.
- IP[7] = TI OR (HW_IRQ_NUM==6 ? synced hw_irq[5] : 0).
- Prescaler:
  - Counts 0..COUNT_DIV-1 while `cause_dc`=0; it holds while `cause_dc`=1.
  - Count increments on the prescaler's wrap cycle.
  - Count wraps 0xFFFF_FFFF -> 0 with no side effect.
- Timer interrupt: TI sets on the cycle Count increments to a value equal to Compare. TI stays set until a Compare write.
- Count write: loads `wdata` and clears the prescaler to 0.
- Compare write: loads `wdata` and clears TI.
- Cause write: updates IP[1:0] = wdata[9:8]; all other written bits are ignored.
- Request logic:
  - `pend` = ip & status_im.
  - `irq_req` next = status_ie & ~status_exl & ~status_erl & |pend.
  - `irq_idx` next = index of the highest set bit of `pend` (7 is highest priority); 0 when `pend` is 0.
  - Both are registered.
- Simultaneous events:
  - Count write and increment in the same cycle: the write wins.
  - Compare write and TI set in the same cycle: the write wins and TI = 0.
  - Count write equal to Compare does not set TI. Only an increment does.

## Timing
- Reset values:
  - Count = 0, Compare = 0xFFFF_FFFF, prescaler = 0, TI = 0.
  - IP[1:0] = 0, all sync flops = 0.
  - `irq_req` = 0, `irq_idx` = 0.
- Writes are visible on `rdata`/`ip`/`ti` the cycle after `we`.
- `hw_irq` edge to IP change: SYNC_STAGES cycles. IP change to `irq_req`: 1 more cycle.
- Status change to `irq_req` update: 1 cycle.
- Count increments exactly once per COUNT_DIV enabled cycles. With COUNT_DIV=1 it increments every cycle.
- Reset mid-operation: every register returns to its reset value asynchronously. The first increment comes COUNT_DIV cycles after reset deasserts.

## Structure
- Add to package `cop0_info`:
  - IDX_CAUSE_TI = 30.
  - IDX_CAUSE_IP_TIMER = 7.
  - IDX_CAUSE_IP_SW_E = 9, IDX_CAUSE_IP_SW_S = 8.
  - IDX_CAUSE_IP_HW_S = 10.
  - RD/SEL constants, reused unchanged.
- Sub-module `cop0_irq_sync`: parametrised width × SYNC_STAGES flop chain with the same async reset, instantiated once for all lines.

## Test plan
- Count prescaler: COUNT_DIV=2, release reset, wait 10 cycles -> Count=5. Write Count=0xFFFF_FFFE, wait 4 cycles -> Count=0 and TI=0.
- Timer interrupt: Compare=0x10, Count=0x0E, status_im[7]=1, ie=1, exl=0 -> TI=1 after 4 cycles. `irq_req`=1 with `irq_idx`=7 one cycle later. Write Compare -> TI=0 and `irq_req`=0 the next cycle.
- Simultaneous: a Compare write lands on the same cycle Count reaches the old Compare -> TI stays 0. A Count write lands on an increment cycle -> Count = wdata.
- HW sync and priority: SYNC_STAGES=2, pulse hw_irq[0] and hw_irq[3] with IM=0xFF -> IP=0x24 after 2 cycles. `irq_idx`=5 after 3 cycles.
- Masking: set IP[1:0]=2'b11 via Cause write. With status_exl=1, `irq_req` stays 0. Clear exl -> `irq_req`=1 and `irq_idx`=1 one cycle later.
- Async reset asserted mid-count with TI=1 -> all outputs match the reset values immediately, without waiting for a clock edge.
